// File: rtl/stavka_d_pkg.sv
// Shared definitions for the stavka_d 4-bit multifunction register:
// datapath width and the operation encoding carried on the control bus.
package stavka_d_pkg;

  localparam int WIDTH = 4;

  typedef enum logic [2:0] {
    OP_HOLD  = 3'd0,
    OP_CLEAR = 3'd1,
    OP_LOAD  = 3'd2,
    OP_INC   = 3'd3,
    OP_DEC   = 3'd4,
    OP_SHL   = 3'd5,
    OP_SHR   = 3'd6,
    OP_PSTEP = 3'd7
  } op_e;

endpackage : stavka_d_pkg

// File: rtl/stavka_d_next.sv
// Combinational next-state function of the multifunction register:
// (current value, data input, operation) -> value to register on the next edge.
module stavka_d_next
  import stavka_d_pkg::*;
(
  input  logic [WIDTH-1:0] r_i,
  input  logic [WIDTH-1:0] d_i,
  input  op_e              op_i,
  output logic [WIDTH-1:0] r_next_o
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO = WIDTH'(2);

  always_comb begin
    // NOTE: default assignment first so no path leaves r_next_o unassigned (no latch).
    r_next_o = r_i;
    case (op_i)
      OP_HOLD:  r_next_o = r_i;
      OP_CLEAR: r_next_o = '0;
      OP_LOAD:  r_next_o = d_i;
      OP_INC:   r_next_o = r_i + ONE;
      OP_DEC:   r_next_o = r_i - ONE;
      OP_SHL:   r_next_o = {r_i[WIDTH-2:0], d_i[0]};
      OP_SHR:   r_next_o = {d_i[WIDTH-1], r_i[WIDTH-1:1]};
      // Adding two never carries into bit 0, so the parity bit is preserved.
      OP_PSTEP: r_next_o = r_i + TWO;
      default:  r_next_o = r_i;
    endcase
  end

endmodule : stavka_d_next

// File: rtl/stavka_d_test.sv
// 4-bit multifunction register (hold/clear/load/count/shift) with synchronous
// active-low reset; data_out is driven directly by the state flops.
module stavka_d_test
  import stavka_d_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic [2:0]       control,
  output logic [WIDTH-1:0] data_out
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;
  op_e              op;

  assign op = op_e'(control);

  stavka_d_next u_next (
    .r_i      (data_q),
    .d_i      (data_in),
    .op_i     (op),
    .r_next_o (data_d)
  );

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignment for state so all flops update together at the edge.
    if (!rst_n) data_q <= '0;
    else        data_q <= data_d;
  end

  assign data_out = data_q;

endmodule : stavka_d_test

// File: tb/tb_stavka_d_test.sv
// Self-checking bench for stavka_d_test: directed vector table, a mid-cycle
// input-glitch sequence and a randomized run against a behavioural model.
module tb_stavka_d_test;
  import stavka_d_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [3:0] data_in;
  logic [2:0] control;
  logic [3:0] data_out;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    logic       rst_n;
    op_e        op;
    logic [3:0] din;
    logic [3:0] exp;
  } vec_t;

  vec_t       vecs[$];
  logic [3:0] exp_q[$];
  string      name_q[$];

  stavka_d_test dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .data_in  (data_in),
    .control  (control),
    .data_out (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [3:0] actual, input logic [3:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: data_out=%b required=%b", name, actual, expected);
    end
  endtask

  // Pop the oldest expected value and compare it with the registered output.
  task automatic score();
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty: data_out=%b required=<queued value>", data_out);
    end else begin
      check(name_q.pop_front(), data_out, exp_q.pop_front());
    end
  endtask

  task automatic apply(input string name, input logic rst, input logic [2:0] c,
                       input logic [3:0] d, input logic [3:0] e);
    @(negedge clk);
    rst_n   = rst;
    control = c;
    data_in = d;
    exp_q.push_back(e);
    name_q.push_back(name);
    @(posedge clk);
    #1;
    score();
  endtask

  function automatic logic [3:0] model(input logic [3:0] r, input logic [3:0] d, input logic [2:0] c);
    int v;
    v = int'(r);
    case (c)
      3'd0: v = v;
      3'd1: v = 0;
      3'd2: v = int'(d);
      3'd3: v = (v + 1) % 16;
      3'd4: v = (v + 15) % 16;
      3'd5: v = ((v * 2) % 16) + (d[0] ? 1 : 0);
      3'd6: v = (v / 2) + (d[3] ? 8 : 0);
      default: v = (v + 2) % 16;
    endcase
    return v[3:0];
  endfunction

  initial begin
    logic [3:0] mdl;
    logic       r_rst;
    logic [2:0] r_c;
    logic [3:0] r_d;

    rst_n   = 1'b1;
    control = 3'd0;
    data_in = 4'd0;

    vecs.push_back('{"reset_hold",    1'b0, OP_HOLD,  4'b0000, 4'b0000});
    vecs.push_back('{"load_1010",     1'b1, OP_LOAD,  4'b1010, 4'b1010});
    vecs.push_back('{"reset_wins",    1'b0, OP_LOAD,  4'b1111, 4'b0000});
    vecs.push_back('{"load_1011",     1'b1, OP_LOAD,  4'b1011, 4'b1011});
    vecs.push_back('{"hold_1",        1'b1, OP_HOLD,  4'b0101, 4'b1011});
    vecs.push_back('{"hold_2",        1'b1, OP_HOLD,  4'b0000, 4'b1011});
    vecs.push_back('{"hold_3",        1'b1, OP_HOLD,  4'b1111, 4'b1011});
    vecs.push_back('{"clear",         1'b1, OP_CLEAR, 4'b1111, 4'b0000});
    vecs.push_back('{"dec_wrap_0000", 1'b1, OP_DEC,   4'b0000, 4'b1111});
    vecs.push_back('{"load_1110",     1'b1, OP_LOAD,  4'b1110, 4'b1110});
    vecs.push_back('{"inc_1",         1'b1, OP_INC,   4'b0000, 4'b1111});
    vecs.push_back('{"inc_wrap",      1'b1, OP_INC,   4'b0000, 4'b0000});
    vecs.push_back('{"dec_after",     1'b1, OP_DEC,   4'b0000, 4'b1111});
    vecs.push_back('{"load_0001",     1'b1, OP_LOAD,  4'b0001, 4'b0001});
    vecs.push_back('{"pstep_1",       1'b1, OP_PSTEP, 4'b0000, 4'b0011});
    vecs.push_back('{"pstep_2",       1'b1, OP_PSTEP, 4'b0000, 4'b0101});
    vecs.push_back('{"pstep_3",       1'b1, OP_PSTEP, 4'b0000, 4'b0111});
    vecs.push_back('{"pstep_4",       1'b1, OP_PSTEP, 4'b0000, 4'b1001});
    vecs.push_back('{"pstep_5",       1'b1, OP_PSTEP, 4'b0000, 4'b1011});
    vecs.push_back('{"pstep_6",       1'b1, OP_PSTEP, 4'b0000, 4'b1101});
    vecs.push_back('{"pstep_7",       1'b1, OP_PSTEP, 4'b0000, 4'b1111});
    vecs.push_back('{"pstep_8_wrap",  1'b1, OP_PSTEP, 4'b0000, 4'b0001});
    vecs.push_back('{"load_1110_b",   1'b1, OP_LOAD,  4'b1110, 4'b1110});
    vecs.push_back('{"pstep_even_wr", 1'b1, OP_PSTEP, 4'b0001, 4'b0000});
    vecs.push_back('{"load_1001",     1'b1, OP_LOAD,  4'b1001, 4'b1001});
    vecs.push_back('{"shl_in1",       1'b1, OP_SHL,   4'b0001, 4'b0011});
    vecs.push_back('{"shr_in0",       1'b1, OP_SHR,   4'b0111, 4'b0001});
    vecs.push_back('{"shr_in1",       1'b1, OP_SHR,   4'b1000, 4'b1000});
    vecs.push_back('{"shl_in0",       1'b1, OP_SHL,   4'b1110, 4'b0000});
    vecs.push_back('{"inc_count_a",   1'b1, OP_INC,   4'b0000, 4'b0001});
    vecs.push_back('{"inc_count_b",   1'b1, OP_INC,   4'b0000, 4'b0010});
    vecs.push_back('{"reset_midcnt",  1'b0, OP_INC,   4'b0000, 4'b0000});
    vecs.push_back('{"inc_resume",    1'b1, OP_INC,   4'b0000, 4'b0001});

    foreach (vecs[i])
      apply(vecs[i].name, vecs[i].rst_n, vecs[i].op, vecs[i].din, vecs[i].exp);

    // Inputs wiggling between edges must not reach data_out before the edge.
    apply("load_0101", 1'b1, OP_LOAD, 4'b0101, 4'b0101);
    @(negedge clk);
    control = OP_CLEAR;
    data_in = 4'b1111;
    #1;
    check("no_comb_path_clear", data_out, 4'b0101);
    control = OP_LOAD;
    #1;
    check("no_comb_path_load", data_out, 4'b1111 & 4'b0101);
    control = OP_HOLD;
    exp_q.push_back(4'b0101);
    name_q.push_back("glitch_then_hold");
    @(posedge clk);
    #1;
    score();

    // Randomized run; the first cycle forces reset so the model starts aligned.
    mdl = 4'b0000;
    for (int n = 0; n < 100; n++) begin
      r_rst = (n == 0) ? 1'b0 : ($urandom_range(0, 9) != 0);
      r_c   = 3'($urandom_range(0, 7));
      r_d   = 4'($urandom_range(0, 15));
      mdl   = r_rst ? model(mdl, r_d, r_c) : 4'b0000;
      apply($sformatf("rand_%0d", n), r_rst, r_c, r_d, mdl);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_stavka_d_test
